// File: rtl/pipeline_front_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_front_ctrl_pkg
//
// Shared definitions for the pipeline front-end register block:
//   - default widths for PC, instruction and decoded-control bundle
//   - the NOP control constant (all-zero control bundle)
//   - the watchdog state encoding RUN / STALL / ERR
//   - the IF/ID bubble constant (instr 0, pc1 0, valid 0)
// -----------------------------------------------------------------------------
package pipeline_front_ctrl_pkg;

  localparam int DEFAULT_PC_W      = 8;
  localparam int DEFAULT_INSTR_W   = 32;
  localparam int DEFAULT_CTRL_W    = 10;
  localparam int DEFAULT_MAX_STALL = 2;

  // An all-zero control bundle does nothing downstream: no register write,
  // no memory access, no branch.
  localparam logic [DEFAULT_CTRL_W-1:0] NOP_CTRL = '0;

  // Watchdog states. The encodings are fixed so existing debug tooling that
  // decodes the raw two-bit state keeps working.
  typedef enum logic [1:0] {
    WD_RUN   = 2'd0,
    WD_STALL = 2'd1,
    WD_ERR   = 2'd2
  } wd_state_e;

  localparam logic [1:0] ST_RUN   = WD_RUN;
  localparam logic [1:0] ST_STALL = WD_STALL;
  localparam logic [1:0] ST_ERR   = WD_ERR;

  // IF/ID register contents at default widths; the bubble is all-zero with
  // valid cleared so downstream logic treats the slot as empty.
  typedef struct packed {
    logic [DEFAULT_INSTR_W-1:0] instr;
    logic [DEFAULT_PC_W-1:0]    pc1;
    logic                       valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: '0, pc1: '0, valid: 1'b0};

endpackage

// File: rtl/pipeline_front_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_front_ctrl_if
//
// Bundles the hazard-unit controls, branch resolution, fetch/decode inputs and
// the pipeline-register outputs of pipeline_front_ctrl.
//
//   master : drives hazard controls, branch, imem_instr, id_ctrl;
//            observes pc, IF/ID, ID/EX and the stall statistics.
//   slave  : the pipeline_front_ctrl side (mirror of master).
//
// Parameters must match the ones given to pipeline_front_ctrl.
// -----------------------------------------------------------------------------
interface pipeline_front_ctrl_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32,
  parameter int CTRL_W  = 10
);

  // Hazard unit / EX stage / fetch / decode inputs
  logic               pc_write;
  logic               IFID_write;
  logic               nop_control;
  logic               branch_taken;
  logic [PC_W-1:0]    branch_target;
  logic [INSTR_W-1:0] imem_instr;
  logic [CTRL_W-1:0]  id_ctrl;

  // Pipeline register outputs
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] IFID_instr;
  logic [PC_W-1:0]    IFID_pc1;
  logic               IFID_valid;
  logic [CTRL_W-1:0]  IDEX_ctrl;
  logic               IDEX_valid;
  logic [15:0]        stall_count;
  logic               stall_err;

  modport master (
    output pc_write, IFID_write, nop_control, branch_taken, branch_target,
           imem_instr, id_ctrl,
    input  pc, IFID_instr, IFID_pc1, IFID_valid, IDEX_ctrl, IDEX_valid,
           stall_count, stall_err
  );

  modport slave (
    input  pc_write, IFID_write, nop_control, branch_taken, branch_target,
           imem_instr, id_ctrl,
    output pc, IFID_instr, IFID_pc1, IFID_valid, IDEX_ctrl, IDEX_valid,
           stall_count, stall_err
  );

endinterface

// File: rtl/pipeline_front_ctrl_stall_watchdog.sv
// -----------------------------------------------------------------------------
// pipeline_front_ctrl_stall_watchdog
//
// Counts stall cycles and flags a stall run longer than a load-use stall can
// legally last.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   stall_cycle  this edge is a stall (nop_control while not flushing)
//   flush        branch flush this edge; ends any stall run
//   stall_count  total stall cycles, saturating at 16'hFFFF
//   stall_err    sticky: a run of stall cycles exceeded MAX_STALL
//
// The FSM sits in RUN with no stall in progress, in STALL while counting a
// run, and in ERR forever (until rst) once a run has become too long.
// -----------------------------------------------------------------------------
module pipeline_front_ctrl_stall_watchdog
  import pipeline_front_ctrl_pkg::*;
#(
  parameter int MAX_STALL = DEFAULT_MAX_STALL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_cycle,
  input  logic        flush,
  output logic [15:0] stall_count,
  output logic        stall_err
);

  // Wide enough to hold MAX_STALL + 1, the value that trips the error.
  localparam int RUN_W = $clog2(MAX_STALL + 2);

  logic [1:0]       state, state_nxt;
  logic [RUN_W-1:0] run_cnt, run_nxt, run_inc;
  logic             err_nxt;

  // Length of the run if this edge extends it: a run entered from RUN starts
  // at one; inside STALL it grows by one.
  assign run_inc = (state == ST_RUN) ? RUN_W'(1) : run_cnt + RUN_W'(1);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    run_nxt   = run_cnt;
    err_nxt   = stall_err;

    case (state)
      ST_RUN, ST_STALL: begin
        if (flush || !stall_cycle) begin
          state_nxt = ST_RUN;
          run_nxt   = '0;
        end else if (run_inc > RUN_W'(MAX_STALL)) begin
          // Checked on entry from RUN too, so MAX_STALL = 0 trips at once.
          state_nxt = ST_ERR;
          run_nxt   = run_inc;
          err_nxt   = 1'b1;
        end else begin
          state_nxt = ST_STALL;
          run_nxt   = run_inc;
        end
      end
      ST_ERR: begin
        // Terminal until reset.
        state_nxt = ST_ERR;
      end
      default: begin
        state_nxt = ST_RUN;
        run_nxt   = '0;
      end
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register in
  // the block samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      run_cnt     <= '0;
      stall_err   <= 1'b0;
      stall_count <= '0;
    end else begin
      state     <= state_nxt;
      run_cnt   <= run_nxt;
      stall_err <= err_nxt;
      if (stall_cycle && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/pipeline_front_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_front_ctrl
//
// Front-end pipeline register block. Owns the PC, the IF/ID register and the
// control half of the ID/EX register, and applies the load-use hazard unit's
// hold/bubble requests and the EX-stage branch flush every cycle.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-high reset
//   bus        pipeline_front_ctrl_if.slave:
//                in : pc_write, IFID_write, nop_control, branch_taken,
//                     branch_target, imem_instr, id_ctrl
//                out: pc, IFID_instr, IFID_pc1, IFID_valid, IDEX_ctrl,
//                     IDEX_valid, stall_count, stall_err
//
// Per-edge priority: reset, branch flush, hazard controls, normal advance.
// A taken branch squashes whatever the hazard unit asked for; the squashed
// instruction was the stalled one, so that edge is not a stall cycle.
// -----------------------------------------------------------------------------
module pipeline_front_ctrl
  import pipeline_front_ctrl_pkg::*;
#(
  parameter int PC_W      = DEFAULT_PC_W,
  parameter int INSTR_W   = DEFAULT_INSTR_W,
  parameter int CTRL_W    = DEFAULT_CTRL_W,
  parameter int MAX_STALL = DEFAULT_MAX_STALL
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_front_ctrl_if.slave  bus
);

  logic            stall_cycle;
  logic [PC_W-1:0] pc_plus1;

  // Wraps modulo 2^PC_W, so pc = all-ones advances to 0 and IF/ID sees 0.
  assign pc_plus1    = bus.pc + PC_W'(1);
  assign stall_cycle = bus.nop_control && !bus.branch_taken;

  // ---------------------------------------------------------------------------
  // PC
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pc <= '0;
    end else if (bus.branch_taken) begin
      bus.pc <= bus.branch_target;
    end else if (bus.pc_write) begin
      bus.pc <= pc_plus1;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.IFID_instr <= INSTR_W'(IFID_BUBBLE.instr);
      bus.IFID_pc1   <= PC_W'(IFID_BUBBLE.pc1);
      bus.IFID_valid <= IFID_BUBBLE.valid;
    end else if (bus.branch_taken) begin
      bus.IFID_instr <= INSTR_W'(IFID_BUBBLE.instr);
      bus.IFID_pc1   <= PC_W'(IFID_BUBBLE.pc1);
      bus.IFID_valid <= IFID_BUBBLE.valid;
    end else if (bus.IFID_write) begin
      bus.IFID_instr <= bus.imem_instr;
      bus.IFID_pc1   <= pc_plus1;
      bus.IFID_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // ID/EX control half. A bubble in IF/ID must not forward whatever the
  // decoder produces from its all-zero instruction, so the bundle is gated
  // by IFID_valid.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.IDEX_ctrl  <= CTRL_W'(NOP_CTRL);
      bus.IDEX_valid <= 1'b0;
    end else if (bus.branch_taken || bus.nop_control) begin
      bus.IDEX_ctrl  <= CTRL_W'(NOP_CTRL);
      bus.IDEX_valid <= 1'b0;
    end else begin
      bus.IDEX_ctrl  <= bus.IFID_valid ? bus.id_ctrl : CTRL_W'(NOP_CTRL);
      bus.IDEX_valid <= bus.IFID_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stall statistics and watchdog
  // ---------------------------------------------------------------------------
  pipeline_front_ctrl_stall_watchdog #(
    .MAX_STALL (MAX_STALL)
  ) u_stall_watchdog (
    .clk         (clk),
    .rst         (rst),
    .stall_cycle (stall_cycle),
    .flush       (bus.branch_taken),
    .stall_count (bus.stall_count),
    .stall_err   (bus.stall_err)
  );

endmodule

// File: tb/tb_pipeline_front_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_front_ctrl
//
// Directed steps followed by a randomized run, each edge compared against a
// behavioural model of the front-end registers and stall statistics.
// -----------------------------------------------------------------------------
module tb_pipeline_front_ctrl;

  localparam int PC_W      = 8;
  localparam int INSTR_W   = 32;
  localparam int CTRL_W    = 10;
  localparam int MAX_STALL = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_front_ctrl_if #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CTRL_W(CTRL_W)
  ) bus ();

  pipeline_front_ctrl #(
    .PC_W(PC_W), .INSTR_W(INSTR_W), .CTRL_W(CTRL_W), .MAX_STALL(MAX_STALL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_instr;
  logic [PC_W-1:0]    m_pc1;
  logic               m_ifv;
  logic [CTRL_W-1:0]  m_ctrl;
  logic               m_idv;
  int                 m_count;
  int                 m_run;    // length of the current stall run
  logic               m_err;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_pc1 = '0; m_ifv = 1'b0;
    m_ctrl = '0; m_idv = 1'b0;
    m_count = 0; m_run = 0; m_err = 1'b0;
  endtask

  // Next state from the current inputs, using the block's rules directly.
  task automatic model_edge();
    int             next_pc;
    logic [CTRL_W-1:0] n_ctrl;
    logic           n_idv;
    if (bus.branch_taken) begin
      m_pc = bus.branch_target;
      m_instr = '0; m_pc1 = '0; m_ifv = 1'b0;
      m_ctrl = '0; m_idv = 1'b0;
      m_run = 0;
    end else begin
      next_pc = (int'(m_pc) + 1) % (1 << PC_W);
      n_ctrl = bus.nop_control ? '0 : (m_ifv ? bus.id_ctrl : '0);
      n_idv  = bus.nop_control ? 1'b0 : m_ifv;
      if (bus.IFID_write) begin
        m_instr = bus.imem_instr;
        m_pc1   = PC_W'(next_pc);
        m_ifv   = 1'b1;
      end
      if (bus.pc_write) m_pc = PC_W'(next_pc);
      m_ctrl = n_ctrl;
      m_idv  = n_idv;
      if (bus.nop_control) begin
        if (m_count < 16'hFFFF) m_count++;
        m_run++;
        if (m_run > MAX_STALL) m_err = 1'b1;
      end else begin
        m_run = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},          32'(bus.pc),          32'(m_pc));
    check({tag, ".IFID_instr"},  bus.IFID_instr,       m_instr);
    check({tag, ".IFID_pc1"},    32'(bus.IFID_pc1),    32'(m_pc1));
    check({tag, ".IFID_valid"},  32'(bus.IFID_valid),  32'(m_ifv));
    check({tag, ".IDEX_ctrl"},   32'(bus.IDEX_ctrl),   32'(m_ctrl));
    check({tag, ".IDEX_valid"},  32'(bus.IDEX_valid),  32'(m_idv));
    check({tag, ".stall_count"}, 32'(bus.stall_count), 32'(m_count));
    check({tag, ".stall_err"},   32'(bus.stall_err),   32'(m_err));
  endtask

  task automatic drive(input logic pw, input logic iw, input logic nop,
                       input logic br, input logic [PC_W-1:0] tgt,
                       input logic [INSTR_W-1:0] instr,
                       input logic [CTRL_W-1:0] ctrl);
    bus.pc_write      = pw;
    bus.IFID_write    = iw;
    bus.nop_control   = nop;
    bus.branch_taken  = br;
    bus.branch_target = tgt;
    bus.imem_instr    = instr;
    bus.id_ctrl       = ctrl;
  endtask

  // Normal advance with imem_instr = 32'hA0 + pc.
  task automatic drive_run();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 32'hA0 + 32'(bus.pc),
          CTRL_W'($urandom_range(1, 1023)));
  endtask

  task automatic drive_stall();
    drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 32'hA0 + 32'(bus.pc),
          CTRL_W'($urandom_range(1, 1023)));
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int count_before;

    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 32'hA0, '0);
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Free run from pc 0
    drive_run(); step("run1");
    check("run1.pc_is_1",    32'(bus.pc), 32'd1);
    check("run1.instr_A0",   bus.IFID_instr, 32'hA0);
    check("run1.pc1_is_1",   32'(bus.IFID_pc1), 32'd1);
    check("run1.idex_inval", 32'(bus.IDEX_valid), 32'd0);
    drive_run(); step("run2");
    check("run2.idex_valid", 32'(bus.IDEX_valid), 32'd1);
    check("run2.pc_is_2",    32'(bus.pc), 32'd2);
    drive_run(); step("run3");
    drive_run(); step("run4");
    drive_run(); step("run5");
    check("run5.pc_is_5",    32'(bus.pc), 32'd5);

    // Single load-use stall at pc 5
    drive_stall(); step("stall1");
    check("stall1.pc_held",  32'(bus.pc), 32'd5);
    check("stall1.instr",    bus.IFID_instr, 32'hA4);
    check("stall1.pc1",      32'(bus.IFID_pc1), 32'd5);
    check("stall1.idexv",    32'(bus.IDEX_valid), 32'd0);
    check("stall1.idexc",    32'(bus.IDEX_ctrl), 32'd0);
    check("stall1.count",    32'(bus.stall_count), 32'd1);
    drive_run(); step("after_stall");
    check("after_stall.pc",  32'(bus.pc), 32'd6);

    // Branch flush together with nop_control: flush wins
    drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 32'hDEAD, 10'h3FF); step("flush");
    check("flush.pc",        32'(bus.pc), 32'h40);
    check("flush.ifv",       32'(bus.IFID_valid), 32'd0);
    check("flush.idv",       32'(bus.IDEX_valid), 32'd0);
    check("flush.count",     32'(bus.stall_count), 32'd1);
    drive_run(); step("post_flush1");
    drive_run(); step("post_flush2");

    // Three consecutive stall cycles trip the watchdog on the third
    count_before = int'(bus.stall_count);
    drive_stall(); step("err_s1");
    check("err_s1.err",      32'(bus.stall_err), 32'd0);
    drive_stall(); step("err_s2");
    check("err_s2.err",      32'(bus.stall_err), 32'd0);
    drive_stall(); step("err_s3");
    check("err_s3.err",      32'(bus.stall_err), 32'd1);
    check("err_s3.count3",   32'(bus.stall_count), 32'(count_before + 3));
    drive_run(); step("err_after1");
    drive_run(); step("err_after2");
    check("err_after.sticky", 32'(bus.stall_err), 32'd1);

    // PC wrap
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 32'h0, '0); step("wrap_br");
    drive_run(); step("wrap");
    check("wrap.pc",         32'(bus.pc), 32'd0);
    check("wrap.pc1",        32'(bus.IFID_pc1), 32'd0);

    // Reset between edges during a stall
    drive_stall(); step("pre_rst_stall");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    check("async_rst.err",   32'(bus.stall_err), 32'd0);
    #1;
    rst = 1'b0;
    drive_run(); step("rst_fetch");
    check("rst_fetch.pc",    32'(bus.pc), 32'd1);
    check("rst_fetch.instr", bus.IFID_instr, 32'hA0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
            PC_W'($urandom), $urandom, CTRL_W'($urandom));
      step($sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
